// File: rtl/da_shift_accumulator.sv
// Bit-serial distributed-arithmetic shift-accumulator for a four-input dot product.
// Consumes one bit-plane per cycle, MSB first, using an offset-binary (sign-folded) ROM.
module da_shift_accumulator #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ROM_W  = 16,
  parameter int unsigned ACC_W  = ROM_W + DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  output logic              rom_cs,
  output logic [2:0]        rom_addr,
  input  logic [ROM_W:0]    rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  y
);

  localparam int unsigned     CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] JMsb = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        x0_q, x1_q, x2_q, x3_q;
  logic [DATA_W-1:0]        x0_d, x1_d, x2_d, x3_d;
  logic [CNT_W-1:0]         j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic                     d0, d1, d2, d3;
  logic signed [ACC_W-1:0]  rom_ext;
  logic signed [ACC_W-1:0]  term;
  logic                     unused_rom_msb;

  assign unused_rom_msb = rom_data[ROM_W];

  // Current bit-plane of the latched samples.
  assign d0 = x0_q[j_q];
  assign d1 = x1_q[j_q];
  assign d2 = x2_q[j_q];
  assign d3 = x3_q[j_q];

  // ROM holds the half-sum table indexed relative to x0; d0 selects the mirrored half.
  assign rom_ext = ACC_W'(signed'(rom_data[ROM_W-1:0]));
  assign term    = d0 ? -rom_ext : rom_ext;

  assign y = acc_q;

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    x3_d      = x3_q;
    j_d       = j_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rom_cs    = 1'b0;
    rom_addr  = 3'b000;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x0_d    = x0;
          x1_d    = x1;
          x2_d    = x2;
          x3_d    = x3;
          j_d     = JMsb;
          state_d = StCalc;
        end
      end

      StCalc: begin
        rom_cs   = 1'b1;
        rom_addr = {d1 ^ d0, d2 ^ d0, d3 ^ d0};
        // The MSB plane carries negative weight in two's complement.
        if (j_q == JMsb) begin
          acc_d = -term;
        end else begin
          acc_d = (acc_q <<< 1) + term;
        end
        if (j_q == '0) begin
          state_d = StDone;
        end else begin
          j_d = j_q - CNT_W'(1);
        end
      end

      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      j_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Directed and randomized checks of the DA shift-accumulator against a closed-form
// bit-weighted sum model.
module tb_da_shift_accumulator;

  localparam int DATA_W = 12;
  localparam int ROM_W  = 16;
  localparam int ACC_W  = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x0, x1, x2, x3;
  logic              rom_cs;
  logic [2:0]        rom_addr;
  logic [ROM_W:0]    rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  y;

  logic [ROM_W:0]    rom [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  da_shift_accumulator #(
    .DATA_W(DATA_W),
    .ROM_W (ROM_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x0       (x0),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .rom_cs   (rom_cs),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  // y = -T_msb * 2^(DATA_W-1) + sum T_j * 2^j, computed directly from the ROM table.
  function automatic logic [ACC_W-1:0] model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    longint s = 0;
    for (int j = 0; j < DATA_W; j++) begin
      logic [2:0]       addr;
      logic [ROM_W-1:0] rw;
      longint           w, t;
      addr = {b[j] ^ a[j], c[j] ^ a[j], d[j] ^ a[j]};
      rw   = rom[addr][ROM_W-1:0];
      w    = longint'(signed'(rw));
      t    = a[j] ? -w : w;
      if (j == DATA_W - 1) s = s - t * (longint'(1) << j);
      else                 s = s + t * (longint'(1) << j);
    end
    return ACC_W'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample set for a single cycle; the DUT must be idle.
  task automatic start(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    x0 = a; x1 = b; x2 = c; x3 = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output bit ok);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    ok = out_valid;
    if (!ok) begin
      errors++;
      $display("FAIL %s: out_valid=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    x0 = 12'h123; x1 = 12'h456; x2 = 12'h789; x3 = 12'hABC;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, rom_cs, rom_addr} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: rdy/vld/cs/addr=%b required 100000",
               {in_ready, out_valid, rom_cs, rom_addr});
    end
    checks++;
    if (y !== '0) begin
      errors++;
      $display("FAIL reset_y: y=%0d required 0", $signed(y));
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_valid_ignored: in_ready=%b rom_cs=%b required 1 0", in_ready, rom_cs);
    end
  endtask

  task automatic test_zero();
    bit bad_addr = 0;
    bit early = 0;
    start(12'h000, 12'h000, 12'h000, 12'h000);
    for (int i = 0; i < DATA_W; i++) begin
      if (rom_cs !== 1'b1 || rom_addr !== 3'b000 || in_ready !== 1'b0) bad_addr = 1;
      if (out_valid !== 1'b0) early = 1;
      tick();
    end
    checks++;
    if (bad_addr) begin
      errors++;
      $display("FAIL zero_addr: rom_cs/rom_addr not 1/000 in every CALC cycle");
    end
    // 13 cycles counted from the accept cycle itself.
    checks++;
    if (early || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_latency: early=%0d out_valid=%b, required 0 and 1", early, out_valid);
    end
    checks++;
    if ($signed(y) !== 30'sd7373) begin
      errors++;
      $display("FAIL zero_y: y=%0d required 7373", $signed(y));
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_neg_one();
    bit bad_addr = 0;
    bit ok;
    start(12'hFFF, 12'h000, 12'h000, 12'h000);
    for (int i = 0; i < DATA_W; i++) begin
      if (rom_cs !== 1'b1 || rom_addr !== 3'b111) bad_addr = 1;
      tick();
    end
    checks++;
    if (bad_addr) begin
      errors++;
      $display("FAIL neg_one_addr: rom_addr not 111 in every CALC cycle");
    end
    wait_done("neg_one_wait", ok);
    checks++;
    if ($signed(y) !== -30'sd1730) begin
      errors++;
      $display("FAIL neg_one_y: y=%0d required -1730", $signed(y));
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] exp;
    bit ok, bad;
    exp = model(12'h5A3, 12'h801, 12'h7FF, 12'h0C4);
    out_ready = 1'b0;
    start(12'h5A3, 12'h801, 12'h7FF, 12'h0C4);
    wait_done("bp_wait", ok);
    checks++;
    if (y !== exp) begin
      errors++;
      $display("FAIL bp_y: y=%0d required %0d", $signed(y), $signed(exp));
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || y !== exp || in_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: out_valid=%b y=%0d in_ready=%b required 1 %0d 0",
               out_valid, $signed(y), in_ready, $signed(exp));
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [ACC_W-1:0] exp;
    bit ok, pulse;
    start(12'h3F0, 12'h111, 12'hE22, 12'h9AB);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, rom_cs, rom_addr} !== 6'b100000 || y !== '0) begin
      errors++;
      $display("FAIL abort_state: rdy/vld/cs/addr=%b y=%0d required 100000 0",
               {in_ready, out_valid, rom_cs, rom_addr}, $signed(y));
    end
    pulse = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) pulse = 1;
      tick();
    end
    checks++;
    if (pulse) begin
      errors++;
      $display("FAIL abort_no_pulse: out_valid seen after abort, required none");
    end
    exp = model(12'h6D5, 12'hA0A, 12'h001, 12'hFF0);
    start(12'h6D5, 12'hA0A, 12'h001, 12'hFF0);
    wait_done("abort_restart_wait", ok);
    checks++;
    if (y !== exp) begin
      errors++;
      $display("FAIL abort_restart_y: y=%0d required %0d", $signed(y), $signed(exp));
    end
    tick();
  endtask

  task automatic test_hold_in_valid();
    logic [ACC_W-1:0] exp;
    int n = 0;
    exp = model(12'h8F1, 12'h2C3, 12'hB4E, 12'h077);
    x0 = 12'h8F1; x1 = 12'h2C3; x2 = 12'hB4E; x3 = 12'h077;
    in_valid = 1'b1;
    tick();
    while (!out_valid && n < 40) begin
      x0 = DATA_W'($urandom); x1 = DATA_W'($urandom);
      x2 = DATA_W'($urandom); x3 = DATA_W'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y !== exp) begin
      errors++;
      $display("FAIL hold_in_valid: out_valid=%b y=%0d required 1 %0d",
               out_valid, $signed(y), $signed(exp));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] a, b, c, d;
    logic [ACC_W-1:0]  exp;
    int bad = 0;
    bit ok;
    for (int k = 0; k < 8; k++) rom[k] = (ROM_W+1)'($urandom);
    for (int i = 0; i < 1000; i++) begin
      a = DATA_W'($urandom); b = DATA_W'($urandom);
      c = DATA_W'($urandom); d = DATA_W'($urandom);
      if (i == 0) begin a = 12'h800; b = 12'h7FF; c = 12'h800; d = 12'hFFF; end
      exp = model(a, b, c, d);
      start(a, b, c, d);
      wait_done("random_wait", ok);
      checks++;
      if (y !== exp) begin
        errors++;
        if (bad < 5) $display("FAIL random_y[%0d]: y=%0d required %0d", i, $signed(y), $signed(exp));
        bad++;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    rom[0] = 17'h1E333;
    rom[1] = 17'h00123;
    rom[2] = 17'h1FF00;
    rom[3] = 17'h04567;
    rom[4] = 17'h18001;
    rom[5] = 17'h07FFF;
    rom[6] = 17'h1ABCD;
    rom[7] = 17'h1F93E;
    test_reset();
    test_zero();
    test_neg_one();
    test_backpressure();
    test_reset_mid_calc();
    test_hold_in_valid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
